// File: rtl/booth_mult_pkg.sv
// booth_mult_pkg: shared types and defaults for the Booth multiplier sequencer.
// FSM states, default sizing, operand-entry layout (tag field with BOOTH_CTRL_TAG_EN).
package booth_mult_pkg;

    localparam int N_DEF        = 32;
    localparam int DEPTH_DEF    = 4;
    localparam int PROD_LAT_DEF = 33;
    localparam int TAG_W_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        HOLD
    } state_t;

    // Entry layout at the default width; the top re-declares
    // the same layout at its own N since packages cannot take
    // parameters.
    typedef struct packed {
`ifdef BOOTH_CTRL_TAG_EN
        logic [TAG_W_DEF-1:0] tag;
`endif
        logic [N_DEF-1:0]     m;
        logic [N_DEF-1:0]     q;
    } op_entry_t;

    // Width of a down-counter that must hold lat-1.
    function automatic int cnt_w(input int lat);
        return (lat <= 2) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/booth_mult_ctrl_if.sv
// booth_mult_ctrl_if: operand, multiplier and result signals of the sequencer.
// slave = controller view, master = producer/multiplier/consumer view; BOOTH_CTRL_TAG_EN adds tags.
interface booth_mult_ctrl_if #(
    parameter int N     = 32,
    parameter int TAG_W = 4
);

    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_m;
    logic [N-1:0]   in_q;
    logic           mul_load;
    logic [N-1:0]   mul_m;
    logic [N-1:0]   mul_q;
    logic [2*N-1:0] mul_p;
    logic           res_valid;
    logic           res_ready;
    logic [2*N-1:0] res_p;
`ifdef BOOTH_CTRL_TAG_EN
    logic [TAG_W-1:0] in_tag;
    logic [TAG_W-1:0] res_tag;
`endif

    if (N < 1 || TAG_W < 1) begin : g_bad_width
        $error("booth_mult_ctrl_if: N and TAG_W must be >= 1");
    end

    modport slave (
        input  in_valid, in_m, in_q, mul_p, res_ready,
`ifdef BOOTH_CTRL_TAG_EN
        input  in_tag,
        output res_tag,
`endif
        output in_ready, mul_load, mul_m, mul_q,
        output res_valid, res_p
    );

    modport master (
        output in_valid, in_m, in_q, mul_p, res_ready,
`ifdef BOOTH_CTRL_TAG_EN
        output in_tag,
        input  res_tag,
`endif
        input  in_ready, mul_load, mul_m, mul_q,
        input  res_valid, res_p
    );

endinterface

// File: rtl/booth_op_fifo.sv
// booth_op_fifo: synchronous FIFO of operand entries, DEPTH a power of 2.
// Ports: clk, rst (sync active-low), push/din, pop/dout (show-ahead head), full, empty.
module booth_op_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         wr_en;
    logic         rd_en;

    // Extra pointer bit separates full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl: buffers signed operand pairs, issues one at a time to a
// fixed-latency Booth multiplier, captures the product onto a valid/ready port.
// Ports: clk, rst (sync active-low), bus (booth_mult_ctrl_if.slave):
//   in_*  operand push, mul_* multiplier side, res_* result port.
// Macro BOOTH_CTRL_TAG_EN: per-op tag in_tag -> res_tag.
module booth_mult_ctrl
    import booth_mult_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int PROD_LAT = PROD_LAT_DEF,
    parameter int TAG_W    = TAG_W_DEF
) (
    input logic              clk,
    input logic              rst,
    booth_mult_ctrl_if.slave bus
);

    localparam int CW = cnt_w(PROD_LAT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PROD_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("booth_mult_ctrl: DEPTH must be a power of 2, >= 2");
    end
    if (PROD_LAT < 2) begin : g_bad_lat
        $error("booth_mult_ctrl: PROD_LAT must be >= 2");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("booth_mult_ctrl: TAG_W must be >= 1");
    end

    typedef struct packed {
`ifdef BOOTH_CTRL_TAG_EN
        logic [TAG_W-1:0] tag;
`endif
        logic [N-1:0]     m;
        logic [N-1:0]     q;
    } entry_t;

    state_t         state;
    state_t         state_n;
    logic [CW-1:0]  cnt;
    logic           in_ready;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    logic           cap;
    logic           done;
    entry_t         din;
    entry_t         head;
    logic [N-1:0]   mul_m_r;
    logic [N-1:0]   mul_q_r;
    logic           res_valid_r;
    logic [2*N-1:0] res_p_r;
`ifdef BOOTH_CTRL_TAG_EN
    logic [TAG_W-1:0] op_tag_r;
    logic [TAG_W-1:0] res_tag_r;
`endif

    // Held low while rst is asserted so nothing is taken in reset.
    assign in_ready = rst & ~full;
    assign push     = bus.in_valid & in_ready;

    assign din.m = bus.in_m;
    assign din.q = bus.in_q;
`ifdef BOOTH_CTRL_TAG_EN
    assign din.tag = bus.in_tag;
`endif

    booth_op_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Last WAIT cycle: product is sampled on the closing edge.
    assign cap  = (state == WAIT) && (cnt == CNT_ONE);
    assign done = (state == HOLD) && bus.res_ready;

    // The head is popped on the edge that enters LOAD, so
    // mul_m/mul_q are already stable while mul_load is high.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    state_n = LOAD;
                    pop     = 1'b1;
                end
            end
            LOAD: begin
                state_n = WAIT;
            end
            WAIT: begin
                if (cap) begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (done) begin
                    pop     = ~empty;
                    state_n = empty ? IDLE : LOAD;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == LOAD) begin
            cnt <= CNT_LOAD;
        end else if (state == WAIT) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mul_m_r <= '0;
            mul_q_r <= '0;
        end else if (pop) begin
            mul_m_r <= head.m;
            mul_q_r <= head.q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            res_valid_r <= 1'b0;
            res_p_r     <= '0;
        end else if (cap) begin
            res_valid_r <= 1'b1;
            res_p_r     <= bus.mul_p;
        end else if (done) begin
            res_valid_r <= 1'b0;
        end
    end

`ifdef BOOTH_CTRL_TAG_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_tag_r  <= '0;
            res_tag_r <= '0;
        end else begin
            if (pop) begin
                op_tag_r <= head.tag;
            end
            if (cap) begin
                res_tag_r <= op_tag_r;
            end
        end
    end

    assign bus.res_tag = res_tag_r;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.mul_load  = (state == LOAD);
    assign bus.mul_m     = mul_m_r;
    assign bus.mul_q     = mul_q_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_p     = res_p_r;

endmodule
